// File: rtl/cyclic_code_pkg.sv
// Shared types and defaults for the cyclic coding datapath (encoder and,
// later, the decoder syndrome stage).
package cyclic_code_pkg;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  localparam int          DEF_N        = 15;
  localparam int          DEF_K        = 11;
  localparam int unsigned DEF_GEN_POLY = 32'h13;  // x^4 + x + 1

  // Number of parity bits of an (n,k) code.
  function automatic int parity_width(input int n, input int k);
    return n - k;
  endfunction

endpackage

// File: rtl/cyclic_lfsr_div.sv
// LFSR polynomial divider by GEN_POLY (bit i = coefficient of x^i).
// data_mode=1: divide, feeding din in at the high end.
// data_mode=0: plain shift, which clears the register while it streams out
// its contents MSB first. msb exposes lfsr[R-1].
module cyclic_lfsr_div
  import cyclic_code_pkg::*;
#(
  parameter int          R        = 4,
  parameter int unsigned GEN_POLY = DEF_GEN_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic data_mode,
  input  logic din,
  output logic msb
);

  localparam logic [R-1:0] POLY = R'(GEN_POLY);

  logic [R-1:0] lfsr;
  logic         fb;

  assign fb  = data_mode & (din ^ lfsr[R-1]);
  assign msb = lfsr[R-1];

  // Remainder register: divide step or clearing shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (shift) begin
      lfsr <= (lfsr << 1) ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/cyclic_encoder_param.sv
// Systematic cyclic (N,K) encoder: K message bits pass straight through,
// followed by R=N-K parity bits, MSB first, over valid/ready handshakes.
// Optional feature macro: CYCLIC_ENC_SHORTEN_EN (in_last ends a message
// early, giving the shortened code). Without it in_last is ignored.
//
// state    | meaning
// S_DATA   | accepting message bits, dividing them into the LFSR
// S_PARITY | streaming the R parity bits out of the LFSR
module cyclic_encoder_param
  import cyclic_code_pkg::*;
#(
  parameter int          N        = DEF_N,
  parameter int          K        = DEF_K,
  parameter int unsigned GEN_POLY = DEF_GEN_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_first,
  output logic out_last,
  output logic busy
);

  localparam int R  = parity_width(N, K);
  localparam int RW = (R > 0) ? R : 1;
  localparam int DW = $clog2(K + 1);
  localparam int PW = $clog2(RW + 1);

  if (K < 1) begin : g_err_k
    $error("cyclic_encoder_param: K must be at least 1");
  end
  if (N <= K) begin : g_err_n
    $error("cyclic_encoder_param: N must exceed K");
  end
  if (((GEN_POLY >> RW) & 32'd1) == 32'd0) begin : g_err_top
    $error("cyclic_encoder_param: GEN_POLY degree-R coefficient must be 1");
  end
  if ((GEN_POLY & 32'd1) == 32'd0) begin : g_err_const
    $error("cyclic_encoder_param: GEN_POLY constant term must be 1");
  end

  state_t        state, state_nx;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic          load_ok, accept, par_load, data_done, par_done;
  logic          lfsr_msb, last_in;

`ifdef CYCLIC_ENC_SHORTEN_EN
  assign last_in = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_in        = 1'b0;
`endif

  assign load_ok = !out_valid || out_ready;
  assign busy    = (dcnt != '0) || (state == S_PARITY);

  cyclic_lfsr_div #(
    .R        (RW),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (accept || par_load),
    .data_mode (accept),
    .din       (in_bit),
    .msb       (lfsr_msb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_DATA;
    else        state <= state_nx;
  end

  // Next state: leave a phase on its final transfer.
  always_comb begin
    state_nx = state;
    case (state)
      S_DATA:   if (data_done) state_nx = S_PARITY;
      S_PARITY: if (par_done)  state_nx = S_DATA;
      default:  state_nx = S_DATA;
    endcase
  end

  // Handshake and transfer strobes.
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    par_load  = 1'b0;
    data_done = 1'b0;
    par_done  = 1'b0;
    if (state == S_DATA) begin
      in_ready  = load_ok;
      accept    = in_valid && load_ok;
      data_done = accept && ((dcnt == DW'(K - 1)) || last_in);
    end else begin
      par_load  = load_ok;
      par_done  = load_ok && (pcnt == PW'(RW - 1));
    end
  end

  // Output register and beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      dcnt      <= '0;
      pcnt      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= in_bit;
      out_first <= (dcnt == '0);
      out_last  <= 1'b0;
      dcnt      <= data_done ? '0 : dcnt + 1'b1;
      if (data_done) pcnt <= '0;
    end else if (par_load) begin
      out_valid <= 1'b1;
      out_bit   <= lfsr_msb;
      out_first <= 1'b0;
      out_last  <= par_done;
      pcnt      <= par_done ? '0 : pcnt + 1'b1;
    end else if (load_ok) begin
      out_valid <= 1'b0;
    end
  end

endmodule
